booth_mult: RTL and testbench

- Sequential signed radix-2 Booth multiplier; the inverse-direction companion of the team's non-restoring sequential divider.
- Produces a 2*WIDTH-bit signed product and reports add/sub operation counts, so results can be cross-checked against the divider (dividend = quotient*divisor + remainder).
- Uses a start/done handshake and performs one Booth step per clock.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/booth_step.sv | 35 +++
 rtl/booth_mult.sv | 128 ++++++++++++
 tb/tb_booth_mult.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// radix-2 Booth pair decode.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // {Qreg[0], q_m1}: 10 subtracts M, 01 adds M, 00/11 leave A alone.
  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   booth_decode = BOOTH_SUB;
      2'b01:   booth_decode = BOOTH_ADD;
      default: booth_decode = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: decode, WIDTH+1-bit add/sub on the
// accumulator, then a 1-bit arithmetic right shift of {A, Q, q_m1}.
import mult_pkg::*;

module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next,
  output logic [1:0]       op
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // The extra accumulator bit keeps A - M exact even for M = -2^(WIDTH-1).
  always_comb begin
    op    = booth_decode(q[0], q_m1);
    m_ext = {m[WIDTH-1], m};
    case (op)
      BOOTH_SUB: sum = acc - m_ext;
      BOOTH_ADD: sum = acc + m_ext;
      default:   sum = acc;
    endcase
    acc_next  = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock with a
// start/done handshake. Optional macro BOOTH_EARLY_EXIT_EN enables early exit.
import mult_pkg::*;

module booth_mult #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CNTW-1:0]    total_add_ops,
  output logic [CNTW-1:0]    total_sub_ops
);

  state_t           state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic [CNTW-1:0]  step;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;
  logic [1:0]       op;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (a_reg),
    .q         (q_reg),
    .q_m1      (q_m1),
    .m         (m_reg),
    .acc_next  (a_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next),
    .op        (op)
  );

`ifdef BOOTH_EARLY_EXIT_EN
  logic [WIDTH-1:0]        mask;
  logic [CNTW-1:0]         remaining;
  logic                    exit_now;
  logic signed [2*WIDTH:0] shifted;

  // The low WIDTH-step bits of Qreg plus q_m1 are the unprocessed multiplier
  // bits; if they are uniform every remaining step is a plain shift.
  always_comb begin
    remaining = CNTW'(WIDTH) - step;
    mask      = {WIDTH{1'b1}} >> step;
    exit_now  = q_m1 ? ((q_reg & mask) == mask) : ((q_reg & mask) == '0);
    shifted   = $signed({a_reg, q_reg}) >>> remaining;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      product       <= '0;
      total_add_ops <= '0;
      total_sub_ops <= '0;
      a_reg         <= '0;
      q_reg         <= '0;
      q_m1          <= 1'b0;
      m_reg         <= '0;
      step          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg         <= '0;
            q_reg         <= multiplier;
            q_m1          <= 1'b0;
            m_reg         <= multiplicand;
            step          <= '0;
            total_add_ops <= '0;
            total_sub_ops <= '0;
            product       <= '0;
            busy          <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
`ifdef BOOTH_EARLY_EXIT_EN
          if (exit_now) begin
            a_reg   <= shifted[2*WIDTH:WIDTH];
            q_reg   <= shifted[WIDTH-1:0];
            product <= shifted[2*WIDTH-1:0];
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          begin
            a_reg <= a_next;
            q_reg <= q_next;
            q_m1  <= q_m1_next;
            step  <= step + CNTW'(1);
            if (op == BOOTH_SUB) total_sub_ops <= total_sub_ops + CNTW'(1);
            if (op == BOOTH_ADD) total_add_ops <= total_add_ops + CNTW'(1);
            if (step == CNTW'(WIDTH - 1)) begin
              product <= {a_next[WIDTH-1:0], q_next};
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult (WIDTH=32) with hand-computed
// products, op counts, latency and reset/abort behaviour.
module tb_booth_mult;

  localparam int WIDTH = 32;
  localparam int CNTW  = $clog2(WIDTH + 1);

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [CNTW-1:0]    total_add_ops;
  logic [CNTW-1:0]    total_sub_ops;

  int n_cmp;
  int n_err;

  booth_mult #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .busy          (busy),
    .done          (done),
    .product       (product),
    .total_add_ops (total_add_ops),
    .total_sub_ops (total_sub_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Launches one multiply, waits (bounded) for done and checks results.
  // exp_lat < 0 skips the latency check; pulse_at > 0 re-asserts start
  // with junk operands that many cycles into the run.
  task automatic applyStimulus(input string tag,
                               input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                               input logic [63:0] exp_prod,
                               input int exp_sub, input int exp_add,
                               input int exp_lat, input int pulse_at);
    int cyc;
    logic seen;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy_on_load"}, 64'(busy), 64'd1);
    checkOutput({tag, "_product_cleared"}, product, 64'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (pulse_at > 0 && cyc == pulse_at) begin
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      cyc++;
      seen = done;
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (exp_lat >= 0) checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    checkOutput({tag, "_product"}, product, exp_prod);
    checkOutput({tag, "_sub_ops"}, 64'(total_sub_ops), 64'(exp_sub));
    checkOutput({tag, "_add_ops"}, 64'(total_add_ops), 64'(exp_add));
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse_ends"}, 64'(done), 64'd0);
    checkOutput({tag, "_product_held"}, product, exp_prod);
    checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int done_pulses;
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", product, 64'd0);
    checkOutput("reset_add", 64'(total_add_ops), 64'd0);
    checkOutput("reset_sub", 64'(total_sub_ops), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BOOTH_EARLY_EXIT_EN
    applyStimulus("m7_q3", 32'd7, 32'd3, 64'd21, 1, 1, 4, 0);
`else
    applyStimulus("m7_q3", 32'd7, 32'd3, 64'd21, 1, 1, 32, 0);
`endif
    applyStimulus("mneg5_q6", 32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2, 1, 1, -1, 0);
    applyStimulus("m12345_qneg1", 32'd12345, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7, 1, 0, -1, 0);
    applyStimulus("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 0, -1, 0);
    applyStimulus("m1_q55", 32'd1, 32'h5555_5555, 64'h0000_0000_5555_5555, 16, 16, 32, 0);
    applyStimulus("start_in_run", 32'd3, 32'd5, 64'd15, 2, 2, -1, 2);

    // Abort mid-run: ten RUN edges, then reset lands on the eleventh.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 32'd9;
    multiplier   = 32'h5555_5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_product", product, 64'd0);
    checkOutput("abort_add", 64'(total_add_ops), 64'd0);
    checkOutput("abort_sub", 64'(total_sub_ops), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_pulses++;
    end
    checkOutput("abort_no_done", 64'(done_pulses), 64'd0);
    checkOutput("abort_still_idle", 64'(busy), 64'd0);

    applyStimulus("after_abort", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
